// File: rtl/exec_issue_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_issue_stage_pkg : opcode, condition and shift-type constants     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package exec_issue_stage_pkg;

    // Data-processing opcodes (ALU encoding)
    localparam logic [3:0] c_op_and = 4'b0000;
    localparam logic [3:0] c_op_eor = 4'b0001;
    localparam logic [3:0] c_op_sub = 4'b0010;
    localparam logic [3:0] c_op_add = 4'b0100;
    localparam logic [3:0] c_op_tst = 4'b1000;
    localparam logic [3:0] c_op_teq = 4'b1001;
    localparam logic [3:0] c_op_cmp = 4'b1010;
    localparam logic [3:0] c_op_orr = 4'b1100;
    localparam logic [3:0] c_op_mov = 4'b1101;
    localparam logic [3:0] c_op_bic = 4'b1110;
    localparam logic [3:0] c_op_mvn = 4'b1111;

    // Condition field encodings
    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;
    localparam logic [3:0] c_cond_nv = 4'b1111;

    // Shift types
    localparam logic [1:0] c_sh_lsl = 2'b00;
    localparam logic [1:0] c_sh_lsr = 2'b01;
    localparam logic [1:0] c_sh_asr = 2'b10;
    localparam logic [1:0] c_sh_ror = 2'b11;

    // Compare/test ops: set flags implicitly, never write a register
    function automatic logic is_test_op(input logic [3:0] op);
        return (op == c_op_tst) || (op == c_op_teq) || (op == c_op_cmp);
    endfunction

    // Ops whose C and V come from the adder rather than the shifter
    function automatic logic is_arith_op(input logic [3:0] op);
        return (op == c_op_add) || (op == c_op_sub) || (op == c_op_cmp);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_issue_stage_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrel_shifter : ARM operand-2 shifter, rotate-immediate, RRX, carry  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module barrel_shifter
    import exec_issue_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [width-1:0] rm,
    input  logic [1:0]       sh_type,
    input  logic [4:0]       sh_amt,
    input  logic             imm_en,
    input  logic [11:0]      imm,
    input  logic             carry_in,
    output logic [width-1:0] operand,
    output logic             carry_out
);

    logic [4:0]       w_amt_m1;
    logic [4:0]       w_rot_amt;
    logic [width-1:0] w_imm_ext;
    logic [width-1:0] w_imm_rot;
    logic [width-1:0] w_shl_m1;
    logic [width-1:0] w_shr_m1;
    logic [width-1:0] w_ror;

    // Shifting by (amount-1) exposes the last bit shifted out at a fixed position
    assign w_amt_m1  = sh_amt - 5'd1;
    assign w_shl_m1  = rm << w_amt_m1;
    assign w_shr_m1  = rm >> w_amt_m1;
    assign w_ror     = (rm >> sh_amt) | (rm << (width - int'(sh_amt)));

    assign w_rot_amt = {imm[11:8], 1'b0};
    assign w_imm_ext = {{(width-8){1'b0}}, imm[7:0]};
    assign w_imm_rot = (w_imm_ext >> w_rot_amt) | (w_imm_ext << (width - int'(w_rot_amt)));

    always_comb begin
        operand   = rm;
        carry_out = carry_in;
        if (imm_en) begin
            operand   = w_imm_rot;
            carry_out = (imm[11:8] == 4'd0) ? carry_in : w_imm_rot[width-1];
        end else begin
            case (sh_type)
                c_sh_lsl: begin
                    if (sh_amt != 5'd0) begin
                        operand   = rm << sh_amt;
                        carry_out = w_shl_m1[width-1];
                    end
                end
                c_sh_lsr: begin
                    if (sh_amt == 5'd0) begin
                        operand   = '0;
                        carry_out = rm[width-1];
                    end else begin
                        operand   = rm >> sh_amt;
                        carry_out = w_shr_m1[0];
                    end
                end
                c_sh_asr: begin
                    if (sh_amt == 5'd0) begin
                        operand   = {width{rm[width-1]}};
                        carry_out = rm[width-1];
                    end else begin
                        operand   = $signed(rm) >>> sh_amt;
                        carry_out = w_shr_m1[0];
                    end
                end
                default: begin
                    // ROR #0 encodes RRX: one-bit rotate through carry
                    if (sh_amt == 5'd0) begin
                        operand   = {carry_in, rm[width-1:1]};
                        carry_out = rm[0];
                    end else begin
                        operand   = w_ror;
                        carry_out = w_ror[width-1];
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_issue_stage : drives external ALU, evaluates condition, holds    |
// | result and NZCV flags in a one-entry output register. Revision: 1.0   |
// +----------------------------------------------------------------------+
module exec_issue_stage
    import exec_issue_stage_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_opcode,
    input  logic             in_s,
    input  logic [3:0]       in_rd,
    input  logic [width-1:0] in_rn_val,
    input  logic [width-1:0] in_rm_val,
    input  logic             in_imm_en,
    input  logic [11:0]      in_imm,
    input  logic [1:0]       in_sh_type,
    input  logic [4:0]       in_sh_amt,
    output logic [3:0]       alu_op,
    output logic [width-1:0] alu_oprd1,
    output logic [width-1:0] alu_oprd2,
    input  logic [width-1:0] alu_result,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rd,
    output logic [width-1:0] out_result,
    output logic             out_wr_en,
    output logic [3:0]       nzcv
);

    logic             r_valid;
    logic [3:0]       r_rd;
    logic [width-1:0] r_result;
    logic             r_wr_en;
    logic [3:0]       r_nzcv;

    logic             w_accept;
    logic             w_cond_pass;
    logic             w_sh_carry;
    logic             w_test_op;
    logic             w_arith_op;
    logic [width-1:0] w_oprd2;

    logic w_n, w_z, w_c, w_v;
    assign {w_n, w_z, w_c, w_v} = r_nzcv;

    barrel_shifter #(.width(width)) u_shifter (
        .rm        (in_rm_val),
        .sh_type   (in_sh_type),
        .sh_amt    (in_sh_amt),
        .imm_en    (in_imm_en),
        .imm       (in_imm),
        .carry_in  (w_c),
        .operand   (w_oprd2),
        .carry_out (w_sh_carry)
    );

    // CMP is a SUB whose result is discarded
    assign alu_op     = (in_opcode == c_op_cmp) ? c_op_sub : in_opcode;
    assign alu_oprd1  = in_rn_val;
    assign alu_oprd2  = w_oprd2;

    assign w_test_op  = is_test_op(in_opcode);
    assign w_arith_op = is_arith_op(in_opcode);
    assign in_ready   = (!r_valid || out_ready) && !flush;
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_cond_pass = 1'b0;
        case (in_cond)
            c_cond_eq: w_cond_pass = w_z;
            c_cond_ne: w_cond_pass = !w_z;
            c_cond_cs: w_cond_pass = w_c;
            c_cond_cc: w_cond_pass = !w_c;
            c_cond_mi: w_cond_pass = w_n;
            c_cond_pl: w_cond_pass = !w_n;
            c_cond_vs: w_cond_pass = w_v;
            c_cond_vc: w_cond_pass = !w_v;
            c_cond_hi: w_cond_pass = w_c && !w_z;
            c_cond_ls: w_cond_pass = !w_c || w_z;
            c_cond_ge: w_cond_pass = (w_n == w_v);
            c_cond_lt: w_cond_pass = (w_n != w_v);
            c_cond_gt: w_cond_pass = !w_z && (w_n == w_v);
            c_cond_le: w_cond_pass = w_z || (w_n != w_v);
            c_cond_al: w_cond_pass = 1'b1;
            default:   w_cond_pass = 1'b0;
        endcase
    end

    // Flags update at the accept edge, so the next instruction sees them directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_rd     <= '0;
            r_result <= '0;
            r_wr_en  <= 1'b0;
            r_nzcv   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_rd     <= in_rd;
            r_result <= alu_result;
            r_wr_en  <= w_cond_pass && !w_test_op;
            if (w_cond_pass && (in_s || w_test_op)) begin
                r_nzcv <= {alu_n, alu_z,
                           w_arith_op ? alu_c : w_sh_carry,
                           w_arith_op ? alu_v : w_v};
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid  = r_valid;
    assign out_rd     = r_rd;
    assign out_result = r_result;
    assign out_wr_en  = r_wr_en;
    assign nzcv       = r_nzcv;

endmodule
`default_nettype wire

// File: tb/tb_exec_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_issue_stage : directed + randomized bench with ALU stub and   |
// | reference model. Revision: 1.0                                        |
// +----------------------------------------------------------------------+
module tb_exec_issue_stage;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [3:0]    in_cond, in_opcode, in_rd;
    logic          in_s, in_imm_en;
    logic [W-1:0]  in_rn_val, in_rm_val;
    logic [11:0]   in_imm;
    logic [1:0]    in_sh_type;
    logic [4:0]    in_sh_amt;
    logic [3:0]    alu_op;
    logic [W-1:0]  alu_oprd1, alu_oprd2, alu_result;
    logic          alu_n, alu_z, alu_c, alu_v;
    logic          flush, out_valid, out_ready, out_wr_en;
    logic [3:0]    out_rd, nzcv;
    logic [W-1:0]  out_result;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic          m_valid, m_wr;
    logic [3:0]    m_rd, m_nzcv;
    logic [W-1:0]  m_result;

    always #5 clk = ~clk;

    exec_issue_stage #(.width(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s), .in_rd(in_rd),
        .in_rn_val(in_rn_val), .in_rm_val(in_rm_val),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .in_sh_type(in_sh_type), .in_sh_amt(in_sh_amt),
        .alu_op(alu_op), .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2),
        .alu_result(alu_result), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_result(out_result), .out_wr_en(out_wr_en), .nzcv(nzcv)
    );

    // ALU behaviour: returns {n, z, c, v, result}
    function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic c, v;
        c = 1'b0; v = 1'b0;
        case (op)
            4'h0, 4'h8: r = a & b;
            4'h1, 4'h9: r = a ^ b;
            4'h2, 4'hA: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h4: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'hC: r = a | b;
            4'hD: r = b;
            4'hE: r = a & ~b;
            4'hF: r = ~b;
            default: begin
                r = a + ~b;
                c = a[0];
                v = b[31];
            end
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    logic [35:0] alu_vec;
    always_comb alu_vec = alu_model(alu_op, alu_oprd1, alu_oprd2);
    assign {alu_n, alu_z, alu_c, alu_v, alu_result} = alu_vec;

    // Operand 2 reference: wide shifts and bit-at-a-time rotation; returns {carry, value}
    function automatic logic [32:0] ref_op2(input logic imm_en, input logic [11:0] imm,
                                            input logic [31:0] rm, input logic [1:0] t,
                                            input logic [4:0] amt, input logic cin);
        logic [63:0] w;
        logic [31:0] r;
        logic c;
        int n;
        if (imm_en) begin
            r = {24'd0, imm[7:0]};
            n = 2 * int'(imm[11:8]);
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            c = (n == 0) ? cin : r[31];
        end else begin
            n = (amt == 5'd0) ? 32 : int'(amt);
            case (t)
                2'd0: begin
                    if (amt == 5'd0) begin
                        r = rm; c = cin;
                    end else begin
                        w = {32'd0, rm} << amt;
                        r = w[31:0]; c = w[32];
                    end
                end
                2'd1: begin
                    w = {rm, 32'd0} >> n;
                    r = w[63:32]; c = w[31];
                end
                2'd2: begin
                    w = $signed({rm, 32'd0}) >>> n;
                    r = w[63:32]; c = w[31];
                end
                default: begin
                    if (amt == 5'd0) begin
                        r = {cin, rm[31:1]}; c = rm[0];
                    end else begin
                        r = rm;
                        for (int i = 0; i < int'(amt); i++) r = {r[0], r[31:1]};
                        c = r[31];
                    end
                end
            endcase
        end
        return {c, r};
    endfunction

    function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;            4'h1: return !z;
            4'h2: return c;            4'h3: return !c;
            4'h4: return n;            4'h5: return !n;
            4'h6: return v;            4'h7: return !v;
            4'h8: return c && !z;      4'h9: return !c || z;
            4'hA: return n == v;       4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        check("out_valid",  out_valid,  m_valid);
        check("out_rd",     out_rd,     m_rd);
        check("out_result", out_result, m_result);
        check("out_wr_en",  out_wr_en,  m_wr);
        check("nzcv",       nzcv,       m_nzcv);
    endtask

    task automatic drive(input logic v, input logic [3:0] cond, input logic [3:0] op, input logic s,
                         input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic ie, input logic [11:0] imm, input logic [1:0] st, input logic [4:0] sa);
        in_valid = v; in_cond = cond; in_opcode = op; in_s = s; in_rd = rd;
        in_rn_val = rn; in_rm_val = rm; in_imm_en = ie; in_imm = imm;
        in_sh_type = st; in_sh_amt = sa;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic cycle();
        logic        ready, acc, pass, tst;
        logic [32:0] o2;
        logic [3:0]  eop;
        logic [35:0] a;
        #2;
        ready = (!m_valid || out_ready) && !flush;
        o2    = ref_op2(in_imm_en, in_imm, in_rm_val, in_sh_type, in_sh_amt, m_nzcv[1]);
        eop   = (in_opcode == 4'hA) ? 4'h2 : in_opcode;
        check("in_ready",  in_ready,  ready);
        check("alu_op",    alu_op,    eop);
        check("alu_oprd1", alu_oprd1, in_rn_val);
        check("alu_oprd2", alu_oprd2, o2[31:0]);
        a    = alu_model(eop, in_rn_val, o2[31:0]);
        pass = cond_ok(in_cond, m_nzcv);
        tst  = (in_opcode == 4'h8) || (in_opcode == 4'h9) || (in_opcode == 4'hA);
        acc  = in_valid && ready;
        @(posedge clk);
        #1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid  = 1'b1;
            m_rd     = in_rd;
            m_result = a[31:0];
            m_wr     = pass && !tst;
            if (pass && (in_s || tst)) begin
                m_nzcv[3] = a[35];
                m_nzcv[2] = a[34];
                if (eop == 4'h4 || eop == 4'h2) m_nzcv[1:0] = a[33:32];
                else                            m_nzcv[1]   = o2[32];
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check_regs();
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_wr = 1'b0; m_rd = '0; m_result = '0; m_nzcv = '0;
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic reset_pulse();
        #2 reset = 1'b1;
        model_reset();
        #1 check_regs();
        #1 reset = 1'b0;
        #1 check("in_ready_after_reset", in_ready, 1'b1);
    endtask

    logic [3:0] saved_nzcv;

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(0, 4'hE, 4'h0, 0, 4'd0, 32'd0, 32'd0, 0, 12'd0, 2'd0, 5'd0);
        model_reset();
        #3 check_regs();
        @(negedge clk) reset = 1'b0;
        #1 check("in_ready_init", in_ready, 1'b1);

        // CMP 5,5 then MOVEQ r3, #7 via register
        drive(1, 4'hE, 4'hA, 0, 4'd0, 32'd5, 32'd5, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        check("cmp_nzcv", nzcv, 4'b0110);
        drive(1, 4'h0, 4'hD, 0, 4'd3, 32'd0, 32'd7, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        check("moveq_wr", out_wr_en, 1'b1);
        check("moveq_res", out_result, 32'd7);

        // Condition fail with flags 0000
        reset_pulse();
        drive(1, 4'h1, 4'h4, 0, 4'd1, 32'd1, 32'd2, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        drive(1, 4'h0, 4'h4, 1, 4'd2, 32'd1, 32'd2, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        check("addeq_wr", out_wr_en, 1'b0);
        check("addeq_nzcv", nzcv, 4'b0000);

        // Shifter edge cases
        drive(1, 4'hE, 4'hD, 1, 4'd4, 32'd0, 32'h8000_0000, 0, 12'd0, 2'd1, 5'd0);
        cycle();
        check("lsr0_res", out_result, 32'd0);
        check("lsr0_nzcv", nzcv, 4'b0110);
        drive(1, 4'hE, 4'hD, 1, 4'd5, 32'd0, 32'h0000_0001, 0, 12'd0, 2'd3, 5'd0);
        cycle();
        check("rrx_res", out_result, 32'h8000_0000);
        check("rrx_nzcv", nzcv, 4'b1010);
        drive(1, 4'hE, 4'hD, 0, 4'd6, 32'd0, 32'd0, 1, {4'd4, 8'hFF}, 2'd0, 5'd0);
        cycle();
        check("imm_res", out_result, 32'hFF00_0000);

        // Back-pressure for three cycles, then release
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hE, 4'h4, 0, 4'(i), $urandom, $urandom, 0, 12'd0, 2'd0, 5'd0);
            cycle();
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'hE, 4'h4, 0, 4'(8 + i), $urandom, $urandom, 0, 12'd0, 2'd0, 5'd0);
            cycle();
            check("bp_stream_valid", out_valid, 1'b1);
        end

        // Flush with a flag-setting instruction present
        saved_nzcv = nzcv;
        flush = 1'b1;
        drive(1, 4'hE, 4'h2, 1, 4'd7, 32'd0, 32'd1, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        check("flush_valid", out_valid, 1'b0);
        check("flush_nzcv", nzcv, saved_nzcv);
        flush = 1'b0;

        // Reset in the middle of a stall
        out_ready = 1'b0;
        drive(1, 4'hE, 4'h4, 1, 4'd9, 32'h7FFF_FFFF, 32'd1, 0, 12'd0, 2'd0, 5'd0);
        cycle();
        cycle();
        reset_pulse();
        out_ready = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), $urandom, $urandom, 1'($urandom), 12'($urandom),
                  2'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_issue_stage.md
EXEC_ISSUE_STAGE -- requirements
Module: exec_issue_stage

Interface
REQ-001 Parameter: width, default 32, datapath width of operands, result and ALU port.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high. Ports are clk (input, 1, rising-edge clock) and reset (input, 1, asynchronous active-high reset).
REQ-003 in_valid input 1: decoded instruction present.
REQ-004 in_ready output 1: stage accepts the instruction this cycle.
REQ-005 in_cond input 4: ARM condition field.
REQ-006 in_opcode input 4: data-processing opcode, ALU encoding.
REQ-007 in_s input 1: set-flags bit.
REQ-008 in_rd input 4: destination register.
REQ-009 in_rn_val input width: operand 1 value.
REQ-010 in_rm_val input width: register operand 2 value.
REQ-011 Immediate-operand inputs:
- in_imm_en input 1: operand 2 is immediate.
- in_imm input 12: {rot[3:0], imm8}.
REQ-012 Shift inputs:
- in_sh_type input 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- in_sh_amt input 5: shift amount.
REQ-013 ALU drive outputs:
- alu_op output 4.
- alu_oprd1 output width.
- alu_oprd2 output width.
REQ-014 ALU return inputs:
- alu_result input width.
- alu_n, alu_z, alu_c, alu_v inputs 1 each.
REQ-015 flush input 1: discard the held and the incoming instruction.
REQ-016 Result handshake:
- out_valid output 1: result register holds an instruction.
- out_ready input 1: downstream consumes it.
REQ-017 Result payload:
- out_rd output 4.
- out_result output width.
- out_wr_en output 1: register write required.
REQ-018 nzcv output 4: architectural flags {N,Z,C,V}.

Function
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !flush; an instruction is accepted when in_valid && in_ready.
REQ-020 Operand 2 source:
- Immediate: imm8 rotated right by 2*rot; shifter carry = C if rot==0, else bit width-1 of the rotated value.
- Register: in_rm_val shifted by the barrel shifter.
REQ-021 Register shift with nonzero amount SHALL follow the ARM rules; carry = last bit shifted out.
REQ-022 Amount-0 cases:
- LSL#0: passthrough, carry = C.
- LSR#0: shift by 32, result 0, carry = rm[31].
- ASR#0: all bits = rm[31], carry = rm[31].
- ROR#0: RRX, {C, rm[31:1]}, carry = rm[0].
REQ-023 alu_op SHALL equal in_opcode, except CMP (1010), which is driven as SUB (0010); alu_oprd1 = in_rn_val and alu_oprd2 = the shifted operand, all combinational.
REQ-024 Condition pass SHALL be evaluated against current nzcv using the ARM table (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL); 1111 SHALL fail.
REQ-025 On accept, the output registers SHALL load: out_rd = in_rd, out_result = alu_result, out_valid = 1 (one-cycle latency).
REQ-026 On accept, out_wr_en SHALL be set to cond_pass && opcode not in {CMP 1010, TST 1000, TEQ 1001}.
REQ-027 On accept with cond_pass && (in_s || opcode in {CMP, TST, TEQ}), nzcv SHALL update:
- N = alu_n, Z = alu_z.
- ADD/SUB/CMP: C = alu_c, V = alu_v.
- All other ops: C = shifter carry, V unchanged.
REQ-028 A failed condition SHALL pass through with out_wr_en = 0 and nzcv unchanged.
REQ-029 The flags used by instruction k+1 SHALL include the update from instruction k, with no bubble.
REQ-030 out_valid SHALL clear on out_ready when no new accept occurs; with out_ready and in_valid both high, the register SHALL be replaced in the same cycle.
REQ-031 Stall: when out_valid && !out_ready, out_rd, out_result, out_wr_en and nzcv SHALL hold.
REQ-032 flush SHALL clear out_valid on the next edge and block any accept in that cycle; nzcv SHALL be unchanged.

Reset
REQ-033 Reset SHALL force out_valid = 0, out_wr_en = 0, out_rd = 0, out_result = 0 and nzcv = 0000 immediately, independent of clk.
REQ-034 Reset mid-stall SHALL drop the held instruction; in_ready SHALL be 1 after reset (when flush is low).

Structure
REQ-035 A shared package SHALL hold the opcode constants (ADD, SUB, CMP, TST, TEQ, BIC, ORR, EOR, MOV, MVN), the 16 condition constants and the shift-type constants.
REQ-036 The barrel shifter (shift, rotate-immediate, RRX, carry-out) SHALL be a sub-module named barrel_shifter; condition evaluation stays inline.

Verification
REQ-037 Flag-setting compare then conditional move:
- Stimulus: CMP rn=5, rm=5, then MOVEQ rd=3, rm=7.
- Response: nzcv = 0110 after the CMP; the MOV retires with out_wr_en = 1 and out_result = 7.
REQ-038 Condition-fail passthrough: nzcv = 0000, ADDNE... then ADDEQ → retires with out_wr_en = 0 and nzcv unchanged.
REQ-039 Shifter edge cases:
- LSR#0 on 0x80000000 → 0, C = 1.
- ROR#0 with C = 1 on 0x00000001 → 0x80000000, C = 1.
- Immediate imm8 = 0xFF, rot = 4 → 0xFF000000.
REQ-040 Back-pressure: out_ready held low 3 cycles with in_valid = 1 → in_ready = 0, outputs held; on release, one result per cycle.
REQ-041 Mid-stream events:
- flush with in_valid = 1 → out_valid = 0 next cycle, nzcv unchanged.
- Async reset pulse mid-stall → all outputs 0 without a clock edge.
